// File: rtl/ioctl_source.sv
// ioctl_source: streams a source byte stream into an ioctl download window,
// pacing write strobes WR_GAP clocks apart and holding the window TAIL_CYC clocks after the last write.
module ioctl_source #(
    parameter int WR_GAP   = 8,
    parameter int TAIL_CYC = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  index,
    input  logic [24:0] length,
    input  logic        src_valid,
    input  logic [7:0]  src_data,
    output logic        src_ready,
    output logic        ioctl_download,
    output logic        ioctl_wr,
    output logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_dout,
    output logic [7:0]  ioctl_index,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, ARM, WAIT_DATA, WRITE, GAP, TAIL} state_t;
    // GAP plus the mandatory WRITE and WAIT_DATA clocks gives exactly WR_GAP between strobes
    localparam logic [7:0] GAP_LD  = 8'(WR_GAP > 2 ? WR_GAP - 3 : 0);
    localparam logic [7:0] TAIL_LD = 8'(TAIL_CYC - 1);
    state_t      state;
    logic [24:0] remain;
    logic [24:0] count;
    logic [7:0]  timer;
    assign src_ready      = state == WAIT_DATA;
    assign ioctl_wr       = state == WRITE;
    assign ioctl_download = state != IDLE;
    assign busy           = state != IDLE;
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state       <= IDLE;
            remain      <= '0;
            count       <= '0;
            timer       <= '0;
            ioctl_addr  <= '0;
            ioctl_dout  <= '0;
            ioctl_index <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    ioctl_index <= index;
                    remain      <= length;
                    count       <= '0;
                    state       <= ARM;
                end
                ARM: if (remain == '0) begin
                    timer <= TAIL_LD;
                    state <= TAIL;
                end else begin
                    state <= WAIT_DATA;
                end
                WAIT_DATA: if (src_valid) begin
                    ioctl_dout <= src_data;
                    ioctl_addr <= count;
                    state      <= WRITE;
                end
                WRITE: begin
                    count  <= count + 25'd1;
                    remain <= remain - 25'd1;
                    if (remain == 25'd1) begin
                        timer <= TAIL_LD;
                        state <= TAIL;
                    end else if (WR_GAP > 2) begin
                        timer <= GAP_LD;
                        state <= GAP;
                    end else begin
                        state <= WAIT_DATA;
                    end
                end
                GAP: if (timer == '0) state <= WAIT_DATA;
                     else timer <= timer - 8'd1;
                TAIL: if (timer == '0) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end else begin
                    timer <= timer - 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
